// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 encodings,
// access-size decode and alignment helpers.
package lsu_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // Encodings 011, 110 and 111 fall through to word.
  function automatic lsu_size_e access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input lsu_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return {off[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage request, data-memory and writeback signals of the load/store unit.
interface lsu_if #(
  parameter int unsigned Data_Width = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [Data_Width-1:0] alu_addr;
  logic [Data_Width-1:0] store_data;
  logic [2:0]            funct3;
  logic                  is_store;
  logic [4:0]            rd_in;
  logic                  mem_req;
  logic                  mem_we;
  logic [Data_Width-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [Data_Width-1:0] mem_wdata;
  logic                  mem_ack;
  logic [Data_Width-1:0] mem_rdata;
  logic                  wb_valid;
  logic [4:0]            wb_rd;
  logic [Data_Width-1:0] wb_data;
  logic                  misalign;
  logic                  bus_err;

  modport slave (
    input  req_valid, alu_addr, store_data, funct3, is_store, rd_in, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           wb_valid, wb_rd, wb_data, misalign, bus_err
  );

  modport master (
    output req_valid, alu_addr, store_data, funct3, is_store, rd_in, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           wb_valid, wb_rd, wb_data, misalign, bus_err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables and data replication, load extract
// and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned Data_Width = 32
) (
  input  logic [1:0]            st_off,
  input  logic [2:0]            st_funct3,
  input  logic [Data_Width-1:0] st_data,
  output logic [3:0]            st_be,
  output logic [Data_Width-1:0] st_wdata,
  input  logic [1:0]            ld_off,
  input  logic [2:0]            ld_funct3,
  input  logic [Data_Width-1:0] ld_rdata,
  output logic [Data_Width-1:0] ld_data
);

  lsu_size_e             st_size;
  lsu_size_e             ld_size;
  logic                  ld_signed;
  logic [Data_Width-1:0] shifted;

  assign st_size   = access_size(st_funct3);
  assign ld_size   = access_size(ld_funct3);
  assign ld_signed = ~ld_funct3[2];
  assign shifted   = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {(Data_Width/8){st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {(Data_Width/16){st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = shifted;
    case (ld_size)
      SZ_BYTE: ld_data = {{(Data_Width-8){ld_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = {{(Data_Width-16){ld_signed & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with ack timeout. Define LSU_MISALIGN_CHECK_EN to
// reject misaligned half/word accesses with a misalign pulse instead of aligning them down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned Data_Width     = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state, state_next;
  logic [CntW-1:0] cnt, cnt_next;
  logic        go_req, finish_load, timeout, misalign_next;
  logic        bad_c;
  lsu_size_e   in_size;
  logic [1:0]  eff_off;

  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic        is_store_q;
  logic [4:0]  rd_q;

  logic [3:0]            st_be;
  logic [Data_Width-1:0] st_wdata;
  logic [Data_Width-1:0] ld_data;

  assign in_size = access_size(bus.funct3);

`ifdef LSU_MISALIGN_CHECK_EN
  assign bad_c   = is_misaligned(in_size, bus.alu_addr[1:0]);
  assign eff_off = bus.alu_addr[1:0];
`else
  assign bad_c   = 1'b0;
  assign eff_off = align_off(in_size, bus.alu_addr[1:0]);
`endif

  lsu_align #(.Data_Width(Data_Width)) u_align (
    .st_off    (eff_off),
    .st_funct3 (bus.funct3),
    .st_data   (bus.store_data),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_off    (off_q),
    .ld_funct3 (funct3_q),
    .ld_rdata  (bus.mem_rdata),
    .ld_data   (ld_data)
  );

  // State and timeout counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state; ack is checked before the timeout so a terminal-count ack completes normally
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    go_req        = 1'b0;
    finish_load   = 1'b0;
    timeout       = 1'b0;
    misalign_next = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bad_c) begin
            misalign_next = 1'b1;
          end else begin
            state_next = REQ;
            cnt_next   = '0;
            go_req     = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_next  = is_store_q ? IDLE : RESP;
          finish_load = ~is_store_q;
          cnt_next    = '0;
        end else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_next = IDLE;
          timeout    = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CntW'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Captured request, memory-side and writeback registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q         <= '0;
      funct3_q      <= '0;
      is_store_q    <= 1'b0;
      rd_q          <= '0;
      bus.req_ready <= 1'b1;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.wb_valid  <= 1'b0;
      bus.wb_rd     <= '0;
      bus.wb_data   <= '0;
      bus.misalign  <= 1'b0;
      bus.bus_err   <= 1'b0;
    end else begin
      bus.req_ready <= (state_next == IDLE);
      bus.mem_req   <= (state_next == REQ);
      bus.mem_we    <= (state_next == REQ) && (go_req ? bus.is_store : is_store_q);
      bus.misalign  <= misalign_next;
      bus.bus_err   <= timeout;
      bus.wb_valid  <= finish_load;
      if (go_req) begin
        off_q         <= eff_off;
        funct3_q      <= bus.funct3;
        is_store_q    <= bus.is_store;
        rd_q          <= bus.rd_in;
        bus.mem_addr  <= {bus.alu_addr[Data_Width-1:2], 2'b00};
        bus.mem_be    <= bus.is_store ? st_be : 4'b1111;
        bus.mem_wdata <= bus.is_store ? st_wdata : '0;
      end
      if (finish_load) begin
        bus.wb_data <= ld_data;
        bus.wb_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed operations queue expected memory,
// writeback and error events; a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic clk;
  logic rst_n;

  lsu_if #(.Data_Width(32)) bus();

  load_store_unit #(.Data_Width(32), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } mem_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  mem_exp_t q_mem[$];
  wb_exp_t  q_wb[$];
  int       pend_err = 0;
  int       pend_mis = 0;
  int       n_checks = 0;
  int       n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    $display("FAIL %s: output asserted with no expectation queued", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  mem_exp_t cur_mem;
  logic     prev_req = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (bus.mem_req) begin
        if (!prev_req) begin
          if (q_mem.size() == 0) unexpected("mem_req");
          else cur_mem = q_mem.pop_front();
        end
        chk("mem_addr", bus.mem_addr, cur_mem.addr);
        chk("mem_be", 32'(bus.mem_be), 32'(cur_mem.be));
        chk("mem_we", 32'(bus.mem_we), 32'(cur_mem.we));
        if (cur_mem.we) chk("mem_wdata", bus.mem_wdata, cur_mem.wdata);
      end
      prev_req = bus.mem_req;
      if (bus.wb_valid) begin
        if (q_wb.size() == 0) unexpected("wb_valid");
        else begin
          wb_exp_t w;
          w = q_wb.pop_front();
          chk("wb_rd", 32'(bus.wb_rd), 32'(w.rd));
          chk("wb_data", bus.wb_data, w.data);
        end
      end
      if (bus.bus_err) begin
        if (pend_err == 0) unexpected("bus_err");
        else begin pend_err--; n_checks++; n_pass++; end
      end
      if (bus.misalign) begin
        if (pend_mis == 0) unexpected("misalign");
        else begin pend_mis--; n_checks++; n_pass++; end
      end
    end
  end

  // ack_wait: REQ cycle index in which mem_ack is driven; negative means never
  task automatic run_op(input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [2:0] f3, input logic st, input logic [4:0] rd,
                        input logic [31:0] rdata, input int ack_wait, input bit exp_mis,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_wb,
                        output int busy, output int reqc);
    mem_exp_t m;
    wb_exp_t  w;
    bit       done;
    if (exp_mis) pend_mis++;
    else begin
      m.addr = exp_addr; m.be = exp_be; m.wdata = exp_wdata; m.we = st;
      q_mem.push_back(m);
      if (ack_wait < 0) pend_err++;
      else if (!st) begin w.rd = rd; w.data = exp_wb; q_wb.push_back(w); end
    end
    @(posedge clk); #1;
    chk("req_ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.alu_addr = addr; bus.store_data = sdata;
    bus.funct3 = f3; bus.is_store = st; bus.rd_in = rd; bus.mem_rdata = rdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    busy = 0; reqc = 0; done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      bus.mem_ack = (ack_wait >= 0) && (c == ack_wait);
      @(negedge clk);
      if (bus.mem_req) reqc++;
      if (bus.req_ready) begin done = 1'b1; break; end
      busy++;
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
    if (!done) $display("FAIL op_done: req_ready never returned (busy %0d)", busy);
    n_checks++;
    if (done) n_pass++;
  endtask

  int busy, reqc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.alu_addr = '0; bus.store_data = '0; bus.funct3 = '0;
    bus.is_store = 1'b0; bus.rd_in = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #12;
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);
    chk("rst_misalign", 32'(bus.misalign), 0);
    chk("rst_bus_err", 32'(bus.bus_err), 0);
    chk("rst_mem_be", 32'(bus.mem_be), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    @(negedge clk); rst_n = 1'b1;

    // LW, ack in the first REQ cycle: 3-cycle occupancy including the accept cycle
    run_op(32'h100, 0, 3'b010, 0, 5'd5, 32'hDEADBEEF, 0, 0, 32'h100, 4'hF, 0, 32'hDEADBEEF, busy, reqc);
    chk("lw_occupancy", 32'(busy + 1), 3);
    run_op(32'h103, 0, 3'b000, 0, 5'd6, 32'h80FFFFFF, 0, 0, 32'h100, 4'hF, 0, 32'hFFFFFF80, busy, reqc);
    run_op(32'h103, 0, 3'b100, 0, 5'd7, 32'h80FFFFFF, 1, 0, 32'h100, 4'hF, 0, 32'h00000080, busy, reqc);
    run_op(32'h102, 32'h1234ABCD, 3'b001, 1, 5'd0, 0, 2, 0, 32'h100, 4'b1100, 32'hABCDABCD, 0, busy, reqc);
    chk("sh_req_cycles", 32'(reqc), 3);
    run_op(32'h201, 32'h000000A5, 3'b000, 1, 5'd0, 0, 0, 0, 32'h200, 4'b0010, 32'hA5A5A5A5, 0, busy, reqc);
    chk("sb_occupancy", 32'(busy + 1), 2);
    run_op(32'h300, 32'hCAFEF00D, 3'b010, 1, 5'd0, 0, 0, 0, 32'h300, 4'hF, 32'hCAFEF00D, 0, busy, reqc);
    run_op(32'h102, 0, 3'b001, 0, 5'd8, 32'h80011234, 0, 0, 32'h100, 4'hF, 0, 32'hFFFF8001, busy, reqc);
    run_op(32'h100, 0, 3'b101, 0, 5'd9, 32'h8001F234, 0, 0, 32'h100, 4'hF, 0, 32'h0000F234, busy, reqc);
    run_op(32'h104, 0, 3'b011, 0, 5'd10, 32'h11223344, 0, 0, 32'h104, 4'hF, 0, 32'h11223344, busy, reqc);
    run_op(32'h108, 32'h55667788, 3'b110, 1, 5'd0, 0, 0, 0, 32'h108, 4'hF, 32'h55667788, 0, busy, reqc);

`ifdef LSU_MISALIGN_CHECK_EN
    run_op(32'h101, 0, 3'b010, 0, 5'd11, 32'h0BADF00D, 0, 1, 0, 0, 0, 0, busy, reqc);
    chk("mis_no_req", 32'(reqc), 0);
`else
    run_op(32'h101, 0, 3'b010, 0, 5'd11, 32'h0BADF00D, 0, 0, 32'h100, 4'hF, 0, 32'h0BADF00D, busy, reqc);
    run_op(32'h103, 32'h0000BEEF, 3'b001, 1, 5'd0, 0, 0, 0, 32'h100, 4'b1100, 32'hBEEFBEEF, 0, busy, reqc);
`endif

    // No ack: bus_err after 16 REQ cycles, then ready again
    run_op(32'h400, 0, 3'b010, 0, 5'd12, 0, -1, 0, 32'h400, 4'hF, 0, 0, busy, reqc);
    chk("timeout_req_cycles", 32'(reqc), 16);
    // Ack on the terminal count completes normally
    run_op(32'h404, 0, 3'b010, 0, 5'd13, 32'h00000077, 15, 0, 32'h404, 4'hF, 0, 32'h00000077, busy, reqc);
    chk("terminal_ack_req_cycles", 32'(reqc), 16);

    // Ack while idle is ignored
    @(posedge clk); #1 bus.mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_ready", 32'(bus.req_ready), 1);

    // Reset in the middle of REQ
    begin
      mem_exp_t m;
      m.addr = 32'h500; m.be = 4'hF; m.wdata = 0; m.we = 1'b0;
      q_mem.push_back(m);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.alu_addr = 32'h500; bus.funct3 = 3'b010; bus.is_store = 1'b0;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreq_rst_mem_req", 32'(bus.mem_req), 0);
    chk("midreq_rst_ready", 32'(bus.req_ready), 1);
    @(posedge clk); #2 rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 1);

    chk("q_mem_empty", 32'(q_mem.size()), 0);
    chk("q_wb_empty", 32'(q_wb.size()), 0);
    chk("pend_err_zero", 32'(pend_err), 0);
    chk("pend_mis_zero", 32'(pend_mis), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter Data_Width, 32, width of the address, data and result paths.
REQ-002 Parameter TIMEOUT_CYCLES, 16, maximum number of REQ-state cycles to wait for mem_ack.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  execute stage presents a memory operation.
REQ-006 req_ready  output  1  unit accepts an operation this cycle.
REQ-007 alu_addr  input  Data_Width  effective address, taken from the ALU result.
REQ-008 store_data  input  Data_Width  rs2 contents for stores.
REQ-009 funct3  input  3  access size and signedness: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-010 is_store  input  1  1 = store, 0 = load.
REQ-011 rd_in  input  5  destination register for a load.
REQ-012 mem_req, mem_we  output  1 each  data-memory request and write strobe.
REQ-013 mem_addr  output  Data_Width  word-aligned address, with alu_addr[1:0] forced to 0.
REQ-014 mem_be  output  4  byte enables; mem_wdata  output  Data_Width  lane-steered store data.
REQ-015 mem_ack  input  1  memory completion; mem_rdata  input  Data_Width  read word.
REQ-016 wb_valid  output  1  load result valid; wb_rd  output  5; wb_data  output  Data_Width.
REQ-017 misalign, bus_err  output  1 each  single-cycle error pulses.

Function
REQ-018 FSM states SHALL be IDLE, REQ and RESP; req_ready = 1 only in IDLE.
REQ-019 Handshake: the unit SHALL capture address, data, funct3, is_store and rd_in when req_valid && req_ready at edge N; mem_req SHALL be 1 from cycle N+1.
REQ-020 In REQ, mem_req, mem_we, mem_addr, mem_be and mem_wdata SHALL hold stable until mem_ack = 1 is sampled.
REQ-021 On mem_ack for a load, the FSM SHALL go to RESP, and wb_valid SHALL be 1 for exactly one cycle, with wb_rd = captured rd.
REQ-022 On mem_ack for a store, the FSM SHALL return directly to IDLE; wb_valid SHALL stay 0.
REQ-023 RESP SHALL return to IDLE unconditionally; the minimum load occupancy is 3 cycles and the minimum store occupancy is 2 cycles.
REQ-024 Store lanes: SB uses mem_be = 1 << addr[1:0], with the byte replicated into all 4 lanes.
REQ-025 Store lanes: SH uses mem_be = 0011 when addr[1] = 0 and 1100 when addr[1] = 1, with the half replicated; SW uses mem_be = 1111.
REQ-026 Load result: wb_data = mem_rdata >> (8 * addr[1:0]), then sign-extended (LB/LH) or zero-extended (LBU/LHU) from the access width.
REQ-027 Load result: mem_be SHALL be 1111 for all loads.
REQ-028 funct3 011, 110 and 111 SHALL be treated as word accesses.
REQ-029 Timeout: a cycle counter SHALL run in REQ; after TIMEOUT_CYCLES cycles without ack, the request SHALL drop, bus_err SHALL pulse 1 cycle, the FSM SHALL go to IDLE and no wb_valid SHALL be produced.
REQ-030 mem_ack in the same cycle as the terminal timeout count SHALL win: normal completion, no bus_err.
REQ-031 mem_ack while not in REQ SHALL be ignored.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, with mem_req, mem_we, wb_valid, misalign and bus_err = 0, and mem_be, mem_addr, mem_wdata, wb_data, wb_rd and the counter = 0.
REQ-033 rst_n asserted mid-REQ SHALL abandon the access; no completion or error pulse SHALL follow reset release.

Configuration
REQ-034 Macro LSU_MISALIGN_CHECK_EN, when defined: a half access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL NOT enter REQ.
REQ-035 Under LSU_MISALIGN_CHECK_EN, such an access SHALL pulse misalign 1 cycle after acceptance and stay in IDLE.
REQ-036 When LSU_MISALIGN_CHECK_EN is undefined: the offending low address bits SHALL be cleared per access size (natural alignment down), the access SHALL proceed normally, and misalign SHALL be tied 0.

Structure
REQ-037 Package lsu_pkg SHALL hold the FSM state enum, the funct3 size/sign localparams and the TIMEOUT_CYCLES default.
REQ-038 Sub-module lsu_align SHALL be combinational and perform store lane steering, byte-enable generation and load extract/extension.

Verification
REQ-039 Sequence: LW at 0x100, then mem_rdata = 0xDEADBEEF with ack 1 cycle later -> wb_data = 0xDEADBEEF, wb_valid is 1 cycle, and 3 cycles elapse from accept to IDLE.
REQ-040 LB at 0x103 with rdata 0x80FFFFFF -> wb_data = 0xFFFFFF80; LBU gives 0x00000080.
REQ-041 SH at 0x102 with store_data 0x1234ABCD -> mem_be = 1100, mem_wdata = 0xABCDABCD, and no wb_valid.
REQ-042 A load with mem_ack never asserted -> bus_err pulses after 16 REQ cycles, then req_ready = 1.
REQ-043 LW at 0x101 with LSU_MISALIGN_CHECK_EN defined -> misalign pulses and mem_req stays 0; with the macro undefined -> mem_addr = 0x100 and the access completes.
REQ-044 rst_n low during REQ -> mem_req = 0 with no clock edge, and nothing further after release.
